// File: rtl/fft_reorder_pingpong_ctrl_if.sv
// Signal bundle between the FFT output stage, the two reorder RAM banks and the
// downstream consumer. The controller uses the master modport.
interface fft_reorder_pingpong_ctrl_if #(
  parameter int unsigned N = 6
) ();
  logic         en_fft;
  logic [N-1:0] cnt_fft;
  logic         ram0_we;
  logic [N-1:0] ram0_addr;
  logic         ram1_we;
  logic [N-1:0] ram1_addr;
  logic         out_bank;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_idx;
  logic         frame_drop;
  logic         busy;

  modport master (
    input  en_fft, cnt_fft, out_ready,
    output ram0_we, ram0_addr, ram1_we, ram1_addr,
    output out_bank, out_valid, out_idx, frame_drop, busy
  );

  modport slave (
    output en_fft, cnt_fft, out_ready,
    input  ram0_we, ram0_addr, ram1_we, ram1_addr,
    input  out_bank, out_valid, out_idx, frame_drop, busy
  );
endinterface

// File: rtl/fft_reorder_pingpong_ctrl.sv
// Ping-pong controller for two single-port reorder banks: natural-order frames are
// written in, drained in bit-reversed address order; frame_drop pulses the cycle after a refused start.
module fft_reorder_pingpong_ctrl #(
  parameter int unsigned N = 6
) (
  input logic                        clk,
  input logic                        areset,
  fft_reorder_pingpong_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    BANK_FREE,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_st_e;

  localparam logic [N-1:0] LAST = '1;

  bank_st_e     st_q [2];
  bank_st_e     st_d [2];
  logic [N-1:0] rd_addr_q [2];
  logic [N-1:0] rd_addr_d [2];
  logic         wr_bank_q, wr_bank_d, wr_active_q, wr_active_d;
  logic         rd_bank_q, rd_bank_d, rd_run_q, rd_run_d;
  logic [N-1:0] rd_cnt_q, rd_cnt_d;
  logic         out_valid_q, out_valid_d, out_bank_q, out_bank_d;
  logic [N-1:0] out_idx_q, out_idx_d;
  logic         frame_drop_q, frame_drop_d;

  logic         drain_end, start_req, start_ok, wr_en, drain_start, issue;
  logic [1:0]   free_now;
  logic [N-1:0] issue_cnt, issue_addr;
  logic         wr_sel0, wr_sel1;

  always_comb begin
    drain_end = out_valid_q & bus.out_ready & (out_idx_q == LAST);
    free_now = '0;
    free_now[out_bank_q] = drain_end;
    start_req = bus.en_fft & (bus.cnt_fft == '0) & ~wr_active_q;
    start_ok = start_req & ((st_q[wr_bank_q] == BANK_FREE) | free_now[wr_bank_q]);
    wr_en = areset & bus.en_fft & (wr_active_q | start_ok);
    // The issue engine moves on to the next FULL bank as soon as the last address of the
    // current one is issued; the bank itself is only freed once its last sample is accepted.
    drain_start = ~rd_run_q & (st_q[rd_bank_q] == BANK_FULL);
    issue = (rd_run_q | drain_start) & (~out_valid_q | bus.out_ready);
    issue_cnt = drain_start ? '0 : rd_cnt_q;
    issue_addr = '0;
    for (int unsigned i = 0; i < N; i++) issue_addr[N-1-i] = issue_cnt[i];
  end

  always_comb begin
    st_d[0] = st_q[0];
    st_d[1] = st_q[1];
    rd_addr_d[0] = rd_addr_q[0];
    rd_addr_d[1] = rd_addr_q[1];
    wr_bank_d = wr_bank_q;
    wr_active_d = wr_active_q;
    rd_bank_d = rd_bank_q;
    rd_run_d = rd_run_q;
    rd_cnt_d = rd_cnt_q;
    out_valid_d = out_valid_q;
    out_bank_d = out_bank_q;
    out_idx_d = out_idx_q;
    frame_drop_d = start_req & ~start_ok;

    if (drain_end) st_d[out_bank_q] = BANK_FREE;
    if (start_ok) begin
      st_d[wr_bank_q] = BANK_FILLING;
      wr_active_d = 1'b1;
    end
    if (wr_en && bus.cnt_fft == LAST) begin
      st_d[wr_bank_q] = BANK_FULL;
      wr_bank_d = ~wr_bank_q;
      wr_active_d = 1'b0;
    end

    if (drain_start) begin
      st_d[rd_bank_q] = BANK_DRAINING;
      rd_run_d = 1'b1;
      rd_cnt_d = '0;
    end
    if (issue) begin
      rd_cnt_d = issue_cnt + 1'b1;
      rd_addr_d[rd_bank_q] = issue_addr;
      out_valid_d = 1'b1;
      out_idx_d = issue_cnt;
      out_bank_d = rd_bank_q;
      if (issue_cnt == LAST) begin
        rd_run_d = 1'b0;
        rd_bank_d = ~rd_bank_q;
      end
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      st_q[0] <= BANK_FREE;
      st_q[1] <= BANK_FREE;
      rd_addr_q[0] <= '0;
      rd_addr_q[1] <= '0;
      wr_bank_q <= 1'b0;
      wr_active_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_run_q <= 1'b0;
      rd_cnt_q <= '0;
      out_valid_q <= 1'b0;
      out_bank_q <= 1'b0;
      out_idx_q <= '0;
      frame_drop_q <= 1'b0;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
      rd_addr_q[0] <= rd_addr_d[0];
      rd_addr_q[1] <= rd_addr_d[1];
      wr_bank_q <= wr_bank_d;
      wr_active_q <= wr_active_d;
      rd_bank_q <= rd_bank_d;
      rd_run_q <= rd_run_d;
      rd_cnt_q <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_bank_q <= out_bank_d;
      out_idx_q <= out_idx_d;
      frame_drop_q <= frame_drop_d;
    end
  end

  // A bank not taking writes keeps its last read address so douta stays stable under stall.
  always_comb begin
    wr_sel0 = ~wr_bank_q & (wr_active_q | (st_q[0] == BANK_FREE) | start_ok);
    wr_sel1 = wr_bank_q & (wr_active_q | (st_q[1] == BANK_FREE) | start_ok);
    bus.ram0_we = wr_en & ~wr_bank_q;
    bus.ram1_we = wr_en & wr_bank_q;
    bus.ram0_addr = wr_sel0 ? bus.cnt_fft
                  : ((issue && !rd_bank_q) ? issue_addr : rd_addr_q[0]);
    bus.ram1_addr = wr_sel1 ? bus.cnt_fft
                  : ((issue && rd_bank_q) ? issue_addr : rd_addr_q[1]);
    bus.out_valid = out_valid_q;
    bus.out_bank = out_bank_q;
    bus.out_idx = out_idx_q;
    bus.frame_drop = frame_drop_q;
    bus.busy = (st_q[0] != BANK_FREE) | (st_q[1] != BANK_FREE);
  end

endmodule

// File: tb/tb_fft_reorder_pingpong_ctrl.sv
// Bench for the reorder ping-pong controller: behavioural RAM banks, a scoreboard of
// expected {bank, index, data} tuples, a vector table and directed multi-cycle sequences.
module tb_fft_reorder_pingpong_ctrl;
  localparam int FR = 64;

  logic clk = 1'b0;
  logic areset = 1'b0;
  always #5 clk = ~clk;

  fft_reorder_pingpong_ctrl_if #(.N(6)) bus ();
  fft_reorder_pingpong_ctrl #(.N(6)) dut (.clk(clk), .areset(areset), .bus(bus));

  logic [15:0] din = '0;
  logic [15:0] mem0 [FR];
  logic [15:0] mem1 [FR];
  logic [15:0] dout0, dout1, dout;
  always @(posedge clk) begin
    if (bus.ram0_we) mem0[bus.ram0_addr] <= din;
    if (bus.ram1_we) mem1[bus.ram1_addr] <= din;
    dout0 <= mem0[bus.ram0_addr];
    dout1 <= mem1[bus.ram1_addr];
  end
  assign dout = bus.out_bank ? dout1 : dout0;

  typedef struct {
    logic       en;
    logic [5:0] cnt;
    logic       we0;
    logic       we1;
    logic [5:0] addr0;
    logic       busy;
  } vec_t;
  vec_t vt [7];

  logic [22:0] sb [$];
  logic [22:0] held;
  int n_vec = 0, n_err = 0;
  int cyc = 0, ready_mode = 0;
  int w0, w1, drops, hs, first_hs, last_hs, last_wr_cyc, rise_cyc;
  logic stall_prev = 1'b0, prev_valid = 1'b0, exp_bank = 1'b0;
  logic [3:0] rpat = 4'b1001;

  function automatic logic [5:0] bitrev(input logic [5:0] v);
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[5-i] = v[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic [22:0] obs;
    obs = {bus.out_bank, bus.out_idx, dout};
    if (bus.ram0_we) w0++;
    if (bus.ram1_we) w1++;
    if ((bus.ram0_we || bus.ram1_we) && bus.cnt_fft == 6'd63) last_wr_cyc = cyc;
    if (bus.out_valid && !prev_valid) rise_cyc = cyc;
    if (bus.frame_drop) drops++;
    if (stall_prev) check("stall_hold", {8'h0, bus.out_valid, obs}, {8'h0, 1'b1, held});
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got %0h expected none", obs);
      end else begin
        check("out", {9'h0, obs}, {9'h0, sb.pop_front()});
      end
      if (hs == 0) first_hs = cyc;
      last_hs = cyc;
      hs++;
    end
    stall_prev = bus.out_valid && !bus.out_ready;
    held = obs;
    prev_valid = bus.out_valid;
  endtask

  task automatic step(input logic en, input logic [5:0] cnt, input logic [15:0] d);
    @(posedge clk);
    #1;
    cyc++;
    bus.en_fft = en;
    bus.cnt_fft = cnt;
    din = d;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = rpat[cyc % 4];
      default: bus.out_ready = 1'b0;
    endcase
    @(negedge clk);
    if (areset) monitor();
  endtask

  task automatic clr();
    w0 = 0; w1 = 0; drops = 0; hs = 0;
  endtask

  task automatic expect_frame(input int fid);
    for (int k = 0; k < FR; k++)
      sb.push_back({exp_bank, 6'(k), 8'(fid), 2'b00, bitrev(6'(k))});
    exp_bank = ~exp_bank;
  endtask

  task automatic send_frame(input int fid, input int start);
    for (int n = start; n < FR; n++) step(1'b1, 6'(n), {8'(fid), 2'b00, 6'(n)});
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step(1'b0, 6'd0, 16'h0);
      n++;
    end
    check("drain_done", sb.size(), 0);
    repeat (3) step(1'b0, 6'd0, 16'h0);
  endtask

  initial begin
    int n;
    bus.en_fft = 1'b0;
    bus.cnt_fft = '0;
    bus.out_ready = 1'b1;
    vt[0] = '{1'b1, 6'd20, 1'b0, 1'b0, 6'd20, 1'b0};
    vt[1] = '{1'b1, 6'd21, 1'b0, 1'b0, 6'd21, 1'b0};
    vt[2] = '{1'b0, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0};
    vt[3] = '{1'b1, 6'd0,  1'b1, 1'b0, 6'd0,  1'b0};
    vt[4] = '{1'b1, 6'd1,  1'b1, 1'b0, 6'd1,  1'b1};
    vt[5] = '{1'b0, 6'd2,  1'b0, 1'b0, 6'd2,  1'b1};
    vt[6] = '{1'b1, 6'd2,  1'b1, 1'b0, 6'd2,  1'b1};

    // Reset state, with a frame start presented while reset is held
    step(1'b1, 6'd0, 16'h0);
    step(1'b1, 6'd0, 16'h0);
    check("reset_state", {bus.ram0_we, bus.ram1_we, bus.out_valid, bus.frame_drop,
                          bus.busy, bus.out_idx, bus.out_bank}, 0);
    bus.en_fft = 1'b0;
    areset = 1'b1;

    // Mid-frame start ignored, then a normal frame with a write gap
    clr();
    expect_frame(1);
    for (int i = 0; i < 7; i++) begin
      step(vt[i].en, vt[i].cnt, {8'd1, 2'b00, vt[i].cnt});
      check($sformatf("vec%0d", i), {bus.ram0_we, bus.ram1_we, bus.ram0_addr, bus.busy},
            {vt[i].we0, vt[i].we1, vt[i].addr0, vt[i].busy});
    end
    send_frame(1, 3);
    wait_drain(200);
    check("single_latency", rise_cyc - last_wr_cyc, 2);
    check("single_hs", hs, 64);
    check("single_span", last_hs - first_hs, 63);
    check("single_writes", {w0[15:0], w1[15:0]}, {16'd64, 16'd0});
    check("single_busy", bus.busy, 0);

    // Backpressure with out_ready 1,0,0,1
    clr();
    ready_mode = 1;
    expect_frame(2);
    send_frame(2, 0);
    wait_drain(600);
    check("bp_hs", hs, 64);
    check("bp_drops", drops, 0);
    ready_mode = 0;

    // Three back-to-back frames
    clr();
    expect_frame(3);
    expect_frame(4);
    expect_frame(5);
    send_frame(3, 0);
    send_frame(4, 0);
    send_frame(5, 0);
    wait_drain(300);
    check("b2b_hs", hs, 192);
    check("b2b_span", last_hs - first_hs, 191);
    check("b2b_drops", drops, 0);
    check("b2b_writes", {w0[15:0], w1[15:0]}, {16'd128, 16'd64});
    check("b2b_busy", bus.busy, 0);

    // Overflow: consumer stalled, third frame must be discarded
    clr();
    ready_mode = 2;
    expect_frame(7);
    expect_frame(8);
    send_frame(7, 0);
    send_frame(8, 0);
    send_frame(9, 0);
    repeat (4) step(1'b0, 6'd0, 16'h0);
    check("ovf_drops", drops, 1);
    check("ovf_writes", {w0[15:0], w1[15:0]}, {16'd64, 16'd64});
    check("ovf_busy", bus.busy, 1);
    ready_mode = 0;
    wait_drain(400);
    check("ovf_hs", hs, 128);

    // Reset mid-drain
    clr();
    expect_frame(10);
    send_frame(10, 0);
    n = 0;
    while (!(bus.out_valid && bus.out_idx == 6'd30) && n < 300) begin
      step(1'b0, 6'd0, 16'h0);
      n++;
    end
    check("reach_idx30", bus.out_idx, 30);
    areset = 1'b0;
    #1;
    check("reset_mid_drain", {bus.out_valid, bus.busy, bus.out_idx, bus.out_bank}, 0);
    sb.delete();
    stall_prev = 1'b0;
    prev_valid = 1'b0;
    exp_bank = 1'b0;
    repeat (2) step(1'b0, 6'd0, 16'h0);
    @(negedge clk);
    areset = 1'b1;
    clr();
    expect_frame(11);
    send_frame(11, 0);
    wait_drain(200);
    check("post_reset_hs", hs, 64);
    check("post_reset_writes", {w0[15:0], w1[15:0]}, {16'd64, 16'd0});
    check("post_reset_busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
